mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: port 0, the multi-cycle CPU datapath (instruction fetch and load/store), and port 1, a DMA/program-loader master.
- Sequences each access against a fixed-latency synchronous memory.
- Returns read data with a one-cycle acknowledge pulse.
- Drives a stall to the CPU control FSM so it holds its current state until the access completes.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 2, memory read latency in cycles (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0  in  1  CPU request; held high until ack0
we0  in  1  CPU write enable (0=read, 1=write)
addr0  in  AW  CPU address
wdata0  in  DW  CPU write data
ack0  out  1  CPU access-complete pulse
req1  in  1  DMA request; held high until ack1
we1  in  1  DMA write enable
addr1  in  AW  DMA address
wdata1  in  DW  DMA write data
ack1  out  1  DMA access-complete pulse
rdata  out  DW  read data, valid in the ack cycle
cpu_stall  out  1  req0 & ~ack0 (combinational)
busy  out  1  high in any state other than IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle

Behaviour:
- Reset (async, immediate, including mid-access) forces:
  - state=IDLE, cnt=0, last=1;
  - ack0=ack1=0, mem_en=mem_we=0;
  - mem_addr=0, mem_wdata=0, rdata=0.
- Any in-flight access is abandoned with no ack.
- All outputs except cpu_stall and busy are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, decision at cycle T:
  - If no req, remain in IDLE.
  - If only one req, grant that port.
  - If both req, grant the port != last (round-robin).
  - On grant: latch owner, we, addr, wdata; set last=owner; go to ISSUE.
- ISSUE, cycle T+1:
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
  - cnt<=1; go to WAIT.
- WAIT, cycles T+2 .. T+1+LAT:
  - mem_en=mem_we=0; mem_addr/mem_wdata hold.
  - When cnt==LAT: for a read, capture mem_rdata into rdata; go to DONE.
  - Otherwise cnt<=cnt+1.
- DONE, cycle T+2+LAT:
  - ack for owner = 1 for exactly one cycle.
  - rdata valid for reads; unchanged for writes.
  - Next state IDLE.
- Access latency, req sampled to ack: LAT+2 cycles. Minimum spacing between grants: LAT+3 cycles.
- req/we/addr/wdata are sampled only in IDLE; changes during an owned access are ignored.
- A requester still high in the cycle after its ack is treated as a new request.
- Losing requester: its req stays pending, it gets no ack, and it is granted in the next IDLE cycle (round-robin guarantees no starvation).
- rdata holds its last captured value until the next read completes.
- ack0 and ack1 are never high simultaneously.
- LAT outside 1..15 is illegal; no runtime check is required.

Test Plan:
1. CPU read alone, LAT=2: req0=1, we0=0, addr0=0x10 in cycle 0. Required: mem_en=1, mem_addr=0x10 in cycle 1; model returns 0xDEADBEEF in cycle 3; ack0=1 and rdata=0xDEADBEEF in cycle 4; cpu_stall high cycles 0-3, low in cycle 4.
2. DMA write: req1=1, we1=1, addr1=0x20, wdata1=0x1234. Required: mem_en=mem_we=1 with mem_wdata=0x1234 in the issue cycle; ack1 pulse 4 cycles after request; rdata unchanged.
3. Simultaneous requests after reset: req0=req1=1 held. Required grant order CPU, DMA, CPU, DMA; ack pulses 5 cycles apart at LAT=2; ack0 and ack1 never both high.
4. Back-to-back CPU requests, req0 held high across acks. Required: second mem_en exactly LAT+3 cycles after the first; no lost or duplicated ack.
5. Reset mid-access: assert rst during WAIT. Required: mem_en, ack0, ack1, busy all 0 immediately; no ack after release; the first request after release completes normally.
6. LAT=1 build: single read. Required: ack 3 cycles after request; rdata equals model data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// mem_port_arbiter : round-robin sharing of one fixed-latency memory port
//                    between the CPU datapath (port 0) and a DMA master (port 1)
// Revision        : 1.0
// =============================================================================
module mem_port_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          cpu_stall,
   output logic          busy,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_CNT = 4'(LAT);

   state_t     state;
   logic [3:0] cnt;
   logic       last;
   logic       owner;
   logic       own_we;
   logic       grant1;

   // Port 1 wins when alone, or when both ask and port 0 was served last.
   assign grant1 = req1 & (~req0 | ~last);

   // The memory strobes are loaded on the grant edge so they are already
   // registered and valid throughout the ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last      <= 1'b1;
         owner     <= 1'b0;
         own_we    <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner     <= grant1;
                  last      <= grant1;
                  own_we    <= grant1 ? we1 : we0;
                  mem_en    <= 1'b1;
                  mem_we    <= grant1 ? we1 : we0;
                  mem_addr  <= grant1 ? addr1 : addr0;
                  mem_wdata <= grant1 ? wdata1 : wdata0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               cnt    <= 4'd1;
               state  <= WAIT;
            end
            WAIT: begin
               if (cnt == LAT_CNT) begin
                  if (!own_we) begin
                     rdata <= mem_rdata;
                  end
                  ack0  <= ~owner;
                  ack1  <= owner;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cpu_stall = req0 & ~ack0;
   assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
// Revision            : 1.0
// =============================================================================
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk, rst;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1, cpu_stall, busy, mem_en, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        b_ack0, b_ack1, b_cpu_stall, b_busy, b_mem_en, b_mem_we;
   logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   logic [31:0] tbmem  [0:255];
   logic [31:0] bmem   [0:255];
   logic [31:0] refmem [0:255];
   int          rd_cyc = -1, b_rd_cyc = -1;
   logic [31:0] rd_data, b_rd_data;

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .cpu_stall(cpu_stall), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut_lat1 (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(b_ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(b_ack1),
      .rdata(b_rdata), .cpu_stall(b_cpu_stall), .busy(b_busy),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
   endfunction

   // Memory models: word array, read data presented only in its due cycle.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) tbmem[mem_addr[9:2]] <= mem_wdata;
         else begin rd_cyc <= cyc + LAT; rd_data <= tbmem[mem_addr[9:2]]; end
      end
      if (b_mem_en) begin
         if (b_mem_we) bmem[b_mem_addr[9:2]] <= b_mem_wdata;
         else begin b_rd_cyc <= cyc + 1; b_rd_data <= bmem[b_mem_addr[9:2]]; end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      mem_rdata   <= (cyc == rd_cyc)   ? rd_data   : $urandom;
      b_mem_rdata <= (cyc == b_rd_cyc) ? b_rd_data : $urandom;
   end

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({ack0, ack1, mem_en, mem_we} !== 4'b0) $display("FAIL reset_strobes: got %b expected 0000", {ack0, ack1, mem_en, mem_we}); else passed++;
      checks++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rdata}); else passed++;
      checks++; if ({busy, cpu_stall} !== 2'b00) $display("FAIL reset_busy_stall: got %b expected 00", {busy, cpu_stall}); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_cpu_read();
      @(negedge clk); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
      for (int k = 0; k <= LAT + 3; k++) begin
         if (k == 0) #1; else @(negedge clk);
         checks++; if (mem_en !== (k == 1)) $display("FAIL rd_mem_en k=%0d: got %b expected %b", k, mem_en, k == 1); else passed++;
         if (k == 1) begin
            checks++; if ({mem_we, mem_addr} !== {1'b0, 32'h10}) $display("FAIL rd_issue: got %b/%h expected 0/00000010", mem_we, mem_addr); else passed++;
         end
         checks++; if ({ack0, ack1} !== {k == LAT + 2, 1'b0}) $display("FAIL rd_ack k=%0d: got %b%b expected %b0", k, ack0, ack1, k == LAT + 2); else passed++;
         checks++; if (cpu_stall !== (k < LAT + 2)) $display("FAIL rd_stall k=%0d: got %b expected %b", k, cpu_stall, k < LAT + 2); else passed++;
         if (k == LAT + 2) begin
            checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rdata); else passed++;
            req0 = 1'b0;
         end
      end
   endtask

   task automatic test_dma_write();
      @(negedge clk); req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h1234;
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         checks++; if (mem_en !== (k == 1)) $display("FAIL wr_mem_en k=%0d: got %b expected %b", k, mem_en, k == 1); else passed++;
         if (k == 1) begin
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h20, 32'h1234}) $display("FAIL wr_issue: got %b/%h/%h expected 1/00000020/00001234", mem_we, mem_addr, mem_wdata); else passed++;
         end
         checks++; if ({ack0, ack1} !== {1'b0, k == LAT + 2}) $display("FAIL wr_ack k=%0d: got %b%b expected 0%b", k, ack0, ack1, k == LAT + 2); else passed++;
         checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL wr_rdata_hold k=%0d: got %h expected deadbeef", k, rdata); else passed++;
         if (k == LAT + 2) begin req1 = 1'b0; we1 = 1'b0; end
      end
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20;
      for (int k = 1; k <= 4 * (LAT + 3) + 2; k++) begin
         logic e0, e1;
         int   idx;
         @(negedge clk);
         idx = (k - (LAT + 2)) / (LAT + 3);
         e0 = (k >= LAT + 2) && ((k - (LAT + 2)) % (LAT + 3) == 0) && (idx < 4) && (idx % 2 == 0);
         e1 = (k >= LAT + 2) && ((k - (LAT + 2)) % (LAT + 3) == 0) && (idx < 4) && (idx % 2 == 1);
         checks++; if ({ack0, ack1} !== {e0, e1}) $display("FAIL rr_ack k=%0d: got %b%b expected %b%b", k, ack0, ack1, e0, e1); else passed++;
         if (e0 || e1) begin
            checks++; if (rdata !== (e0 ? 32'hDEADBEEF : 32'h1234)) $display("FAIL rr_rdata k=%0d: got %h", k, rdata); else passed++;
         end
         if (idx == 3 && e1) begin req0 = 1'b0; req1 = 1'b0; end
      end
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      @(negedge clk); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      for (int k = 1; k <= 3 * (LAT + 3); k++) begin
         logic e_en, e_ack;
         @(negedge clk);
         e_en  = ((k - 1) % (LAT + 3) == 0) && (k <= 1 + (LAT + 3));
         e_ack = (k >= LAT + 2) && ((k - (LAT + 2)) % (LAT + 3) == 0) && (k <= 2 * LAT + 5);
         checks++; if (mem_en !== e_en) $display("FAIL b2b_mem_en k=%0d: got %b expected %b", k, mem_en, e_en); else passed++;
         checks++; if (ack0 !== e_ack) $display("FAIL b2b_ack k=%0d: got %b expected %b", k, ack0, e_ack); else passed++;
         if (ack0 === 1'b1) acks++;
         if (k == 2 * LAT + 5) req0 = 1'b0;
      end
      checks++; if (acks != 2) $display("FAIL b2b_ack_count: got %0d expected 2", acks); else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      @(negedge clk); @(negedge clk);
      rst = 1'b1; req0 = 1'b0;
      #1;
      checks++; if ({mem_en, ack0, ack1, busy} !== 4'b0) $display("FAIL mid_reset_outputs: got %b expected 0000", {mem_en, ack0, ack1, busy}); else passed++;
      checks++; if (rdata !== 32'h0) $display("FAIL mid_reset_rdata: got %h expected 0", rdata); else passed++;
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if ({ack0, ack1, busy} !== 3'b0) $display("FAIL post_reset_quiet k=%0d: got %b expected 000", k, {ack0, ack1, busy}); else passed++;
      end
      req0 = 1'b1; addr0 = 32'h20;
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         checks++; if (ack0 !== (k == LAT + 2)) $display("FAIL post_reset_ack k=%0d: got %b expected %b", k, ack0, k == LAT + 2); else passed++;
      end
      checks++; if (rdata !== 32'h1234) $display("FAIL post_reset_rdata: got %h expected 00001234", rdata); else passed++;
      req0 = 1'b0;
   endtask

   task automatic test_lat1();
      pulse_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++; if ({b_ack0, b_ack1} !== {k == 3, 1'b0}) $display("FAIL lat1_ack k=%0d: got %b%b expected %b0", k, b_ack0, b_ack1, k == 3); else passed++;
         checks++; if (b_mem_en !== (k == 1)) $display("FAIL lat1_mem_en k=%0d: got %b expected %b", k, b_mem_en, k == 1); else passed++;
         checks++; if (b_busy !== (k <= 3)) $display("FAIL lat1_busy k=%0d: got %b expected %b", k, b_busy, k <= 3); else passed++;
         if (k <= 3) begin
            checks++; if (b_cpu_stall !== (k < 3)) $display("FAIL lat1_stall k=%0d: got %b expected %b", k, b_cpu_stall, k < 3); else passed++;
         end
         if (k == 3) begin
            checks++; if (b_rdata !== 32'hCAFEF00D) $display("FAIL lat1_rdata: got %h expected cafef00d", b_rdata); else passed++;
         end
         if (k == 4) req0 = 1'b0;
      end
   endtask

   // Transaction-level model: an access granted at cycle c issues at c+1,
   // acknowledges at c+LAT+2 and frees the port for a new decision at c+LAT+3.
   task automatic test_random();
      int          idle_from, en_cyc, ack_cyc, c;
      logic        m_last, m_owner, m_we, e0, e1, win;
      logic [31:0] m_addr, m_wdata, m_rdata, exp_rd;
      for (int i = 0; i < 256; i++) refmem[i] = tbmem[i];
      pulse_reset();
      idle_from = cyc; en_cyc = -1; ack_cyc = -1;
      m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = 0; m_rdata = 0; exp_rd = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         c  = cyc;
         e0 = (c == ack_cyc) && !m_owner;
         e1 = (c == ack_cyc) && m_owner;
         if (c == ack_cyc && !m_we) m_rdata = exp_rd;
         checks++; if ({ack0, ack1} !== {e0, e1}) $display("FAIL rand_ack c=%0d: got %b%b expected %b%b", c, ack0, ack1, e0, e1); else passed++;
         checks++; if (mem_en !== (c == en_cyc)) $display("FAIL rand_mem_en c=%0d: got %b expected %b", c, mem_en, c == en_cyc); else passed++;
         if (c == en_cyc) begin
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wdata}) $display("FAIL rand_issue c=%0d: got %b/%h/%h expected %b/%h/%h", c, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata); else passed++;
         end
         checks++; if (rdata !== m_rdata) $display("FAIL rand_rdata c=%0d: got %h expected %h", c, rdata, m_rdata); else passed++;
         checks++; if (busy !== (c < idle_from)) $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, c < idle_from); else passed++;
         if (!req0 || e0) begin
            req0 = ($urandom_range(0, 2) != 0);
            we0 = 1'($urandom_range(0, 1)); addr0 = 32'($urandom_range(0, 15)) << 2; wdata0 = $urandom;
         end
         if (!req1 || e1) begin
            req1 = ($urandom_range(0, 2) != 0);
            we1 = 1'($urandom_range(0, 1)); addr1 = 32'($urandom_range(0, 15)) << 2; wdata1 = $urandom;
         end
         #1;
         checks++; if (cpu_stall !== (req0 && !e0)) $display("FAIL rand_stall c=%0d: got %b expected %b", c, cpu_stall, req0 && !e0); else passed++;
         if (c >= idle_from && (req0 || req1)) begin
            if (req0 && req1) win = !m_last;
            else              win = req1;
            m_owner = win; m_last = win;
            m_we    = win ? we1 : we0;
            m_addr  = win ? addr1 : addr0;
            m_wdata = win ? wdata1 : wdata0;
            if (m_we) refmem[m_addr[9:2]] = m_wdata;
            else      exp_rd = refmem[m_addr[9:2]];
            en_cyc = c + 1; ack_cyc = c + LAT + 2; idle_from = c + LAT + 3;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (LAT + 4) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin tbmem[i] = init_val(i); bmem[i] = init_val(i); end
      tbmem[4] = 32'hDEADBEEF;
      bmem[4]  = 32'hDEADBEEF;
      bmem[64] = 32'hCAFEF00D;
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_lat1();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
